// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the memory-stage requesters, the access controller and
// the single-port data memory. The slave modport is the controller's view.
interface dmem_access_ctrl_if #(
  parameter int DEPTH_WORDS = 1024
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic          core_req;
  logic          core_we;
  logic [31:0]   core_addr;
  logic [31:0]   core_wdata;
  logic [2:0]    store_sel_M;
  logic [2:0]    load_sel_M;
  logic          core_stall;
  logic [31:0]   core_rdata;
  logic          core_misalign;

  logic          dbg_req;
  logic          dbg_we;
  logic [31:0]   dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [31:0]   dbg_rdata;

  logic          err_valid;
  logic [31:0]   err_addr;
  logic          err_clr;

  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, store_sel_M, load_sel_M,
    output core_stall, core_rdata, core_misalign,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output err_valid, err_addr,
    input  err_clr,
    output mem_we, mem_be, mem_waddr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, store_sel_M, load_sel_M,
    input  core_stall, core_rdata, core_misalign,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  err_valid, err_addr,
    output err_clr,
    input  mem_we, mem_be, mem_waddr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: core/debug arbitration with starvation guard,
// byte-lane store steering, load formatting and misalign capture.
// Optional performance counters are built when DMEM_PERF_EN is defined.
module dmem_access_ctrl #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_access_ctrl_if.slave   bus,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_dbg_cnt
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {ARB_CORE, ARB_DBG} arb_state_t;

  arb_state_t state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       grant_core, grant_dbg;
  logic       core_bad;
  logic       core_stall;
  logic       unused_bits;

  assign unused_bits = ^{bus.core_addr[31:AW+2], bus.dbg_addr[31:AW+2], bus.dbg_addr[1:0]};

  function automatic logic [3:0] st_be(input logic [2:0] sel, input logic [1:0] off);
    case (sel)
      3'b000:  return 4'b0001 << off;
      3'b001:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] sel, input logic [31:0] wdata);
    case (sel)
      3'b000:  return {4{wdata[7:0]}};
      3'b001:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] ld_format(input logic [2:0] sel, input logic [1:0] off,
                                            input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = signed'(word[{off, 3'b000} +: 8]);
    h = signed'(off[1] ? word[31:16] : word[15:0]);
    case (sel)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Illegal store encodings are folded into the misalign path.
  function automatic logic access_bad(input logic we, input logic [2:0] ssel,
                                      input logic [2:0] lsel, input logic [1:0] off);
    if (we) begin
      case (ssel)
        3'b000:  return 1'b0;
        3'b001:  return off[0];
        3'b010:  return |off;
        default: return 1'b1;
      endcase
    end
    case (lsel)
      3'b001, 3'b101: return off[0];
      3'b010:         return |off;
      default:        return 1'b0;
    endcase
  endfunction

  assign core_bad = access_bad(bus.core_we, bus.store_sel_M, bus.load_sel_M, bus.core_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_CORE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    unique case (state)
      ARB_CORE: begin
        grant_core = bus.core_req;
        grant_dbg  = ~bus.core_req & bus.dbg_req;
        if (grant_dbg || !bus.dbg_req) begin
          starve_nxt = 4'd0;
        end else begin
          starve_nxt = starve_cnt + 4'd1;
          if (starve_nxt == 4'(STARVE_LIMIT)) state_nxt = ARB_DBG;
        end
      end
      ARB_DBG: begin
        // A debug requester that has gone away forfeits the owed slot.
        grant_dbg  = bus.dbg_req;
        grant_core = bus.core_req & ~bus.dbg_req;
        starve_nxt = 4'd0;
        state_nxt  = ARB_CORE;
      end
      default: state_nxt = ARB_CORE;
    endcase
    if (!rst_n) begin
      grant_core = 1'b0;
      grant_dbg  = 1'b0;
    end
  end

  assign core_stall     = rst_n & bus.core_req & ~grant_core;
  assign bus.core_stall = core_stall;
  assign bus.dbg_gnt    = grant_dbg;

  always_comb begin
    bus.mem_we        = 1'b0;
    bus.mem_be        = 4'b0000;
    bus.mem_waddr     = '0;
    bus.mem_wdata     = 32'h0;
    bus.core_rdata    = 32'h0;
    bus.core_misalign = 1'b0;
    if (grant_core) begin
      bus.mem_waddr = bus.core_addr[AW+1:2];
      if (core_bad) begin
        bus.core_misalign = 1'b1;
      end else if (bus.core_we) begin
        bus.mem_we    = 1'b1;
        bus.mem_be    = st_be(bus.store_sel_M, bus.core_addr[1:0]);
        bus.mem_wdata = st_data(bus.store_sel_M, bus.core_wdata);
      end else begin
        bus.core_rdata = ld_format(bus.load_sel_M, bus.core_addr[1:0], bus.mem_rdata);
      end
    end else if (grant_dbg) begin
      bus.mem_waddr = bus.dbg_addr[AW+1:2];
      if (bus.dbg_we) begin
        bus.mem_we    = 1'b1;
        bus.mem_be    = 4'b1111;
        bus.mem_wdata = bus.dbg_wdata;
      end
    end
  end

  // Response/error registers; a fresh capture takes precedence over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dbg_rvalid <= 1'b0;
      bus.dbg_rdata  <= 32'h0;
      bus.err_valid  <= 1'b0;
      bus.err_addr   <= 32'h0;
    end else begin
      bus.dbg_rvalid <= grant_dbg & ~bus.dbg_we;
      if (grant_dbg && !bus.dbg_we) bus.dbg_rdata <= bus.mem_rdata;
      if (bus.core_misalign && (!bus.err_valid || bus.err_clr)) begin
        bus.err_valid <= 1'b1;
        bus.err_addr  <= bus.core_addr;
      end else if (bus.err_clr) begin
        bus.err_valid <= 1'b0;
        bus.err_addr  <= 32'h0;
      end
    end
  end

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'h0;
      perf_dbg_cnt   <= 32'h0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'h0, core_stall};
      perf_dbg_cnt   <= perf_dbg_cnt + {31'h0, grant_dbg};
    end
  end
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_dbg_cnt   = 32'h0;
`endif
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural byte-enabled memory.
module tb_dmem_access_ctrl;
  localparam int DEPTH = 1024;

  localparam int S_STALL = 0, S_RDATA = 1, S_MIS = 2, S_GNT = 3, S_RVALID = 4,
                 S_DRDATA = 5, S_ERRV = 6, S_ERRA = 7, S_WE = 8, S_BE = 9,
                 S_WADDR = 10, S_WDATA = 11;

  typedef struct {
    int          due;
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_clear;
  logic [31:0] perf_stall_cnt, perf_dbg_cnt;
  logic [31:0] mem [0:DEPTH-1];
  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  dmem_access_ctrl_if #(.DEPTH_WORDS(DEPTH)) bus();

  dmem_access_ctrl #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_dbg_cnt   (perf_dbg_cnt)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_waddr];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= 32'h0;
    end else if (bus.mem_we) begin
      for (int l = 0; l < 4; l++)
        if (bus.mem_be[l]) mem[bus.mem_waddr][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_STALL:  return {31'h0, bus.core_stall};
      S_RDATA:  return bus.core_rdata;
      S_MIS:    return {31'h0, bus.core_misalign};
      S_GNT:    return {31'h0, bus.dbg_gnt};
      S_RVALID: return {31'h0, bus.dbg_rvalid};
      S_DRDATA: return bus.dbg_rdata;
      S_ERRV:   return {31'h0, bus.err_valid};
      S_ERRA:   return bus.err_addr;
      S_WE:     return {31'h0, bus.mem_we};
      S_BE:     return {28'h0, bus.mem_be};
      S_WADDR:  return 32'(bus.mem_waddr);
      S_WDATA:  return bus.mem_wdata;
      default:  return 32'hDEAD_0000;
    endcase
  endfunction

  task automatic expect_at(input int off, input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.due = cyc + off;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    #2;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] ssel, input logic [2:0] lsel);
    bus.core_req    = req;
    bus.core_we     = we;
    bus.core_addr   = addr;
    bus.core_wdata  = wdata;
    bus.store_sel_M = ssel;
    bus.load_sel_M  = lsel;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.dbg_req   = req;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
  endtask

  task automatic idle();
    drive_core(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 3'b010);
    drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    bus.err_clr = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] ssel);
    drive_core(1'b1, 1'b1, addr, wdata, ssel, 3'b010);
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] lsel);
    drive_core(1'b1, 1'b0, addr, 32'h0, 3'b010, lsel);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_clear = 1'b1;
    idle();

    // Reset state
    expect_at(0, "rst_errv", S_ERRV, 0);
    expect_at(0, "rst_erra", S_ERRA, 0);
    expect_at(0, "rst_rvalid", S_RVALID, 0);
    expect_at(0, "rst_drdata", S_DRDATA, 0);
    expect_at(0, "rst_we", S_WE, 0);
    expect_at(0, "rst_stall", S_STALL, 0);
    tick();
    mem_clear = 1'b0;
    rst_n     = 1'b1;
    tick();

    // Byte store / loads
    store(32'h103, 32'hFFFF_FFA5, 3'b000);
    expect_at(0, "sb_we", S_WE, 1);
    expect_at(0, "sb_be", S_BE, 4'b1000);
    expect_at(0, "sb_wdata", S_WDATA, 32'hA5A5_A5A5);
    expect_at(0, "sb_waddr", S_WADDR, 32'h40);
    expect_at(0, "sb_stall", S_STALL, 0);
    tick();
    load(32'h103, 3'b100);
    expect_at(0, "lbu_rdata", S_RDATA, 32'h0000_00A5);
    expect_at(0, "lbu_we", S_WE, 0);
    tick();
    store(32'h103, 32'h0000_0080, 3'b000);
    tick();
    load(32'h103, 3'b000);
    expect_at(0, "lb_rdata", S_RDATA, 32'hFFFF_FF80);
    tick();

    // Half store / loads
    store(32'h202, 32'h1234_BEEF, 3'b001);
    expect_at(0, "sh_be", S_BE, 4'b1100);
    expect_at(0, "sh_wdata", S_WDATA, 32'hBEEF_BEEF);
    tick();
    load(32'h202, 3'b001);
    expect_at(0, "lh_rdata", S_RDATA, 32'hFFFF_BEEF);
    tick();
    load(32'h202, 3'b101);
    expect_at(0, "lhu_rdata", S_RDATA, 32'h0000_BEEF);
    tick();

    // Word store / load
    store(32'h10, 32'hDEAD_BEEF, 3'b010);
    expect_at(0, "sw_be", S_BE, 4'b1111);
    expect_at(0, "sw_wdata", S_WDATA, 32'hDEAD_BEEF);
    tick();
    load(32'h10, 3'b010);
    expect_at(0, "lw_rdata", S_RDATA, 32'hDEAD_BEEF);
    tick();
    load(32'h10, 3'b111);
    expect_at(0, "lundef_rdata", S_RDATA, 32'hDEAD_BEEF);
    tick();

    // Misalign capture, hold, illegal store, clear, clear-vs-capture
    load(32'h301, 3'b010);
    expect_at(0, "mis1_pulse", S_MIS, 1);
    expect_at(0, "mis1_we", S_WE, 0);
    expect_at(0, "mis1_stall", S_STALL, 0);
    expect_at(1, "mis1_errv", S_ERRV, 1);
    expect_at(1, "mis1_erra", S_ERRA, 32'h301);
    tick();
    store(32'h305, 32'h5555_5555, 3'b010);
    expect_at(0, "mis2_pulse", S_MIS, 1);
    expect_at(0, "mis2_we", S_WE, 0);
    expect_at(1, "mis2_erra", S_ERRA, 32'h301);
    tick();
    store(32'h300, 32'h6666_6666, 3'b011);
    expect_at(0, "ill_pulse", S_MIS, 1);
    expect_at(0, "ill_we", S_WE, 0);
    tick();
    idle();
    bus.err_clr = 1'b1;
    expect_at(0, "idle_mis", S_MIS, 0);
    expect_at(1, "clr_errv", S_ERRV, 0);
    expect_at(1, "clr_erra", S_ERRA, 0);
    tick();
    bus.err_clr = 1'b0;
    load(32'h309, 3'b010);
    expect_at(1, "mis3_erra", S_ERRA, 32'h309);
    tick();
    load(32'h30B, 3'b001);
    bus.err_clr = 1'b1;
    expect_at(1, "clrwin_errv", S_ERRV, 1);
    expect_at(1, "clrwin_erra", S_ERRA, 32'h30B);
    tick();
    idle();
    bus.err_clr = 1'b1;
    expect_at(1, "clr2_errv", S_ERRV, 0);
    tick();
    bus.err_clr = 1'b0;

    // Starvation pattern: 4 core grants then one forced debug slot
    for (int i = 0; i < 10; i++) begin
      load(32'h10, 3'b010);
      drive_dbg(1'b1, 1'b0, 32'h80, 32'h0);
      expect_at(0, "starve_stall", S_STALL, (i % 5 == 4) ? 1 : 0);
      expect_at(0, "starve_gnt", S_GNT, (i % 5 == 4) ? 1 : 0);
      if (i % 5 != 4) expect_at(0, "starve_rdata", S_RDATA, 32'hDEAD_BEEF);
      expect_at(1, "starve_rvalid", S_RVALID, (i % 5 == 4) ? 1 : 0);
      tick();
    end
    idle();

    // Debug write then read with core idle
    drive_dbg(1'b1, 1'b1, 32'h43, 32'h1234_5678);
    expect_at(0, "dw_gnt", S_GNT, 1);
    expect_at(0, "dw_we", S_WE, 1);
    expect_at(0, "dw_be", S_BE, 4'b1111);
    expect_at(0, "dw_wdata", S_WDATA, 32'h1234_5678);
    expect_at(0, "dw_waddr", S_WADDR, 32'h10);
    expect_at(1, "dw_rvalid", S_RVALID, 0);
    tick();
    drive_dbg(1'b1, 1'b0, 32'h40, 32'h0);
    expect_at(0, "dr_gnt", S_GNT, 1);
    expect_at(0, "dr_we", S_WE, 0);
    expect_at(1, "dr_rvalid", S_RVALID, 1);
    expect_at(1, "dr_rdata", S_DRDATA, 32'h1234_5678);
    tick();
    idle();
    load(32'h40, 3'b010);
    expect_at(0, "core_rd_dbgword", S_RDATA, 32'h1234_5678);
    expect_at(1, "dr_rvalid_drop", S_RVALID, 0);
    tick();

    // Asynchronous reset mid-stream
    load(32'h301, 3'b010);
    expect_at(1, "pre_rst_errv", S_ERRV, 1);
    tick();
    load(32'h10, 3'b010);
    drive_dbg(1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    tick();
    store(32'h500, 32'hCAFE_F00D, 3'b010);
    #1 rst_n = 1'b0;
    expect_at(0, "arst_we", S_WE, 0);
    expect_at(0, "arst_be", S_BE, 0);
    expect_at(0, "arst_stall", S_STALL, 0);
    expect_at(0, "arst_gnt", S_GNT, 0);
    expect_at(0, "arst_errv", S_ERRV, 0);
    expect_at(0, "arst_erra", S_ERRA, 0);
    expect_at(0, "arst_rvalid", S_RVALID, 0);
    expect_at(0, "arst_drdata", S_DRDATA, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load(32'h10, 3'b010);
      drive_dbg(1'b1, 1'b0, 32'h40, 32'h0);
      expect_at(0, "post_rst_stall", S_STALL, (i == 4) ? 1 : 0);
      expect_at(0, "post_rst_gnt", S_GNT, (i == 4) ? 1 : 0);
      tick();
    end
    idle();
    load(32'h500, 3'b010);
    expect_at(0, "rst_write_dropped", S_RDATA, 32'h0);
    tick();
    idle();
    tick();
    tick();
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
